// File: rtl/dma_timing_control.sv
// -----------------------------------------------------------------------------
// dma_timing_control
//   Timing and priority controller for a four-channel DMA engine running in
//   single-transfer mode. Arbitrates the channel requests (fixed or rotating
//   priority), runs the HRQ/HLDA hold handshake with the CPU and walks the
//   SI -> S0 -> S1 -> S2 -> S3 -> S4 transfer states, driving DACK, the bus
//   strobes and the datapath control pulses. Every output is a flop.
//
// Ports
//   CLK, RESET_N               clock, asynchronous active-low reset
//   DREQ[CHANNELS]             level-sensitive channel requests
//   HLDA                       hold acknowledge from the CPU
//   EOP_N_IN                   external end-of-process (active low)
//   cmdDisable                 blocks new arbitration (not an abort)
//   cmdRotatingPriority        0 = fixed priority, 1 = rotating priority
//   channelMask[CHANNELS]      1 = channel masked
//   xferType[CHANNELS*2]       per channel: 00 verify, 01 write, 10 read,
//                              11 treated as verify
//   wordCountZero[CHANNELS]    this transfer is the channel's terminal count
//   HRQ                        hold request to the CPU
//   DACK[CHANNELS]             one-hot acknowledge
//   AEN, ADSTB                 address enable, upper-address strobe
//   MEMR_N, MEMW_N             memory strobes (active low)
//   IOR_OUT_N, IOW_OUT_N       I/O strobes (active low)
//   EOP_N_OUT                  terminal-count indication (active low)
//   activeChannel              channel being serviced
//   programCondition           CPU may program the register file
//   loadAddr                   datapath drives the address (S1 only)
//   updateCurrentAddressReg    one-cycle address update pulse (S4)
//   updateCurrentWordCountReg  one-cycle word-count update pulse (S4)
//   intEOP                     one-cycle end-of-process pulse (S4)
// -----------------------------------------------------------------------------
module dma_timing_control #(
  parameter int CHANNELS      = 4,
  parameter int XFERTYPEWIDTH = 2
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic [CHANNELS-1:0]               DREQ,
  input  logic                              HLDA,
  input  logic                              EOP_N_IN,
  input  logic                              cmdDisable,
  input  logic                              cmdRotatingPriority,
  input  logic [CHANNELS-1:0]               channelMask,
  input  logic [CHANNELS*XFERTYPEWIDTH-1:0] xferType,
  input  logic [CHANNELS-1:0]               wordCountZero,
  output logic                              HRQ,
  output logic [CHANNELS-1:0]               DACK,
  output logic                              AEN,
  output logic                              ADSTB,
  output logic                              MEMR_N,
  output logic                              MEMW_N,
  output logic                              IOR_OUT_N,
  output logic                              IOW_OUT_N,
  output logic                              EOP_N_OUT,
  output logic [1:0]                        activeChannel,
  output logic                              programCondition,
  output logic                              loadAddr,
  output logic                              updateCurrentAddressReg,
  output logic                              updateCurrentWordCountReg,
  output logic                              intEOP
);

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } dmaStateT;

  localparam logic [XFERTYPEWIDTH-1:0] XFER_WRITE = XFERTYPEWIDTH'(1);
  localparam logic [XFERTYPEWIDTH-1:0] XFER_READ  = XFERTYPEWIDTH'(2);

  dmaStateT            state;
  logic [1:0]          rotPtr;     // highest-priority channel in rotating mode
  logic                eopLatch;   // external EOP seen during S1..S3

  logic [CHANNELS-1:0]      pending;
  logic [1:0]               basePtr;
  logic [1:0]               winner;
  logic [XFERTYPEWIDTH-1:0] typeOf [CHANNELS];
  logic [XFERTYPEWIDTH-1:0] curType;
  logic                     isWrite;
  logic                     isRead;
  logic [CHANNELS-1:0]      ackOneHot;
  logic                     inDataPhase;

  assign pending = DREQ & ~channelMask;

  // Priority scan starting at basePtr; iterating from the far end down makes
  // the nearest pending channel the last (and therefore winning) assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a path that skips it would infer a latch.
    basePtr = cmdRotatingPriority ? rotPtr : 2'd0;
    winner  = basePtr;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[basePtr + 2'(i)]) begin
        winner = basePtr + 2'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      typeOf[i] = xferType[i*XFERTYPEWIDTH +: XFERTYPEWIDTH];
    end
  end

  // Type 11 matches neither decode and therefore behaves as verify.
  assign curType     = typeOf[activeChannel];
  assign isWrite     = (curType == XFER_WRITE);
  assign isRead      = (curType == XFER_READ);
  assign ackOneHot   = CHANNELS'(1) << activeChannel;
  assign inDataPhase = (state == S1) || (state == S2) || (state == S3);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state                     <= SI;
      rotPtr                    <= 2'd0;
      eopLatch                  <= 1'b0;
      HRQ                       <= 1'b0;
      DACK                      <= '0;
      AEN                       <= 1'b0;
      ADSTB                     <= 1'b0;
      MEMR_N                    <= 1'b1;
      MEMW_N                    <= 1'b1;
      IOR_OUT_N                 <= 1'b1;
      IOW_OUT_N                 <= 1'b1;
      EOP_N_OUT                 <= 1'b1;
      activeChannel             <= 2'd0;
      programCondition          <= 1'b1;
      loadAddr                  <= 1'b0;
      updateCurrentAddressReg   <= 1'b0;
      updateCurrentWordCountReg <= 1'b0;
      intEOP                    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values; the defaults below are then safely
      // overridden by the state-specific assignments that follow.
      ADSTB                     <= 1'b0;
      loadAddr                  <= 1'b0;
      updateCurrentAddressReg   <= 1'b0;
      updateCurrentWordCountReg <= 1'b0;
      intEOP                    <= 1'b0;
      EOP_N_OUT                 <= 1'b1;
      programCondition          <= 1'b0;

      if (inDataPhase && !HLDA) begin
        // CPU took the bus back mid-transfer: drop everything, no updates.
        state            <= SI;
        HRQ              <= 1'b0;
        AEN              <= 1'b0;
        DACK             <= '0;
        MEMR_N           <= 1'b1;
        MEMW_N           <= 1'b1;
        IOR_OUT_N        <= 1'b1;
        IOW_OUT_N        <= 1'b1;
        programCondition <= 1'b1;
      end else begin
        if (inDataPhase && !EOP_N_IN) begin
          eopLatch <= 1'b1;
        end

        case (state)
          SI: begin
            eopLatch <= 1'b0;
            if (|pending && !cmdDisable) begin
              state         <= S0;
              HRQ           <= 1'b1;
              activeChannel <= winner;
            end else begin
              programCondition <= ~HLDA;
            end
          end

          S0: begin
            if (!DREQ[activeChannel]) begin
              state            <= SI;
              HRQ              <= 1'b0;
              programCondition <= ~HLDA;
            end else if (HLDA) begin
              state    <= S1;
              AEN      <= 1'b1;
              ADSTB    <= 1'b1;
              loadAddr <= 1'b1;
              DACK     <= ackOneHot;
            end
          end

          S1: begin
            state     <= S2;
            MEMR_N    <= ~isRead;
            IOR_OUT_N <= ~isWrite;
          end

          S2: begin
            state     <= S3;
            MEMW_N    <= ~isWrite;
            IOW_OUT_N <= ~isRead;
          end

          S3: begin
            state                     <= S4;
            MEMR_N                    <= 1'b1;
            MEMW_N                    <= 1'b1;
            IOR_OUT_N                 <= 1'b1;
            IOW_OUT_N                 <= 1'b1;
            updateCurrentAddressReg   <= 1'b1;
            updateCurrentWordCountReg <= 1'b1;
            // An EOP arriving in S3 has not reached eopLatch yet, so it is
            // folded in directly.
            intEOP    <= wordCountZero[activeChannel] | eopLatch | ~EOP_N_IN;
            EOP_N_OUT <= ~wordCountZero[activeChannel];
          end

          S4: begin
            state            <= SI;
            HRQ              <= 1'b0;
            AEN              <= 1'b0;
            DACK             <= '0;
            programCondition <= ~HLDA;
            if (cmdRotatingPriority) begin
              rotPtr <= activeChannel + 2'd1;
            end
          end

          default: begin
            state <= SI;
            HRQ   <= 1'b0;
            AEN   <= 1'b0;
            DACK  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_timing_control.sv
module tb_dma_timing_control;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       EOP_N_IN;
  logic       cmdDisable;
  logic       cmdRotatingPriority;
  logic [3:0] channelMask;
  logic [7:0] xferType;
  logic [3:0] wordCountZero;
  logic       HRQ;
  logic [3:0] DACK;
  logic       AEN;
  logic       ADSTB;
  logic       MEMR_N;
  logic       MEMW_N;
  logic       IOR_OUT_N;
  logic       IOW_OUT_N;
  logic       EOP_N_OUT;
  logic [1:0] activeChannel;
  logic       programCondition;
  logic       loadAddr;
  logic       updateCurrentAddressReg;
  logic       updateCurrentWordCountReg;
  logic       intEOP;

  dma_timing_control #(.CHANNELS(4), .XFERTYPEWIDTH(2)) dut (
    .CLK                       (CLK),
    .RESET_N                   (RESET_N),
    .DREQ                      (DREQ),
    .HLDA                      (HLDA),
    .EOP_N_IN                  (EOP_N_IN),
    .cmdDisable                (cmdDisable),
    .cmdRotatingPriority       (cmdRotatingPriority),
    .channelMask               (channelMask),
    .xferType                  (xferType),
    .wordCountZero             (wordCountZero),
    .HRQ                       (HRQ),
    .DACK                      (DACK),
    .AEN                       (AEN),
    .ADSTB                     (ADSTB),
    .MEMR_N                    (MEMR_N),
    .MEMW_N                    (MEMW_N),
    .IOR_OUT_N                 (IOR_OUT_N),
    .IOW_OUT_N                 (IOW_OUT_N),
    .EOP_N_OUT                 (EOP_N_OUT),
    .activeChannel             (activeChannel),
    .programCondition          (programCondition),
    .loadAddr                  (loadAddr),
    .updateCurrentAddressReg   (updateCurrentAddressReg),
    .updateCurrentWordCountReg (updateCurrentWordCountReg),
    .intEOP                    (intEOP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference: a transfer is a busy interval, mOff counts
  // cycles since the grant (0 = waiting for HLDA, 1..4 = bus cycles).
  // ---------------------------------------------------------------------------
  bit         mBusy;
  int         mOff;
  int         mCh;
  int         mPtr;
  bit         mEop;
  bit         mTc;
  bit         mIeop;
  bit         mPc;
  logic [1:0] mType;

  task automatic modelReset();
    mBusy = 0; mOff = 0; mCh = 0; mPtr = 0;
    mEop = 0; mTc = 0; mIeop = 0; mPc = 1; mType = 2'b00;
  endtask

  function automatic int pick(input logic [3:0] p, input int base);
    for (int k = 0; k < 4; k++) begin
      if (p[(base + k) % 4]) return (base + k) % 4;
    end
    return base;
  endfunction

  task automatic modelStep();
    logic [3:0] pend;
    pend = DREQ & ~channelMask;
    if (!mBusy) begin
      mEop = 0;
      if (pend != 4'b0 && !cmdDisable) begin
        mBusy = 1;
        mOff  = 0;
        mCh   = pick(pend, cmdRotatingPriority ? mPtr : 0);
        mType = xferType[2*mCh +: 2];
      end
    end else if (mOff == 0) begin
      if (!DREQ[mCh]) mBusy = 0;
      else if (HLDA) mOff = 1;
    end else if (mOff <= 3) begin
      if (!HLDA) begin
        mBusy = 0;
      end else begin
        if (!EOP_N_IN) mEop = 1;
        if (mOff == 3) begin
          mTc   = wordCountZero[mCh];
          mIeop = mTc || mEop;
        end
        mOff++;
      end
    end else begin
      mBusy = 0;
      if (cmdRotatingPriority) mPtr = (mCh + 1) % 4;
    end
    mPc = !mBusy && !HLDA;
  endtask

  function automatic logic [31:0] expVec();
    bit         dackOn, rdPhase, wrPhase, fin, isWr, isRd, first;
    logic [3:0] dk;
    logic [18:0] v;
    dackOn  = mBusy && mOff >= 1 && mOff <= 4;
    rdPhase = mBusy && (mOff == 2 || mOff == 3);
    wrPhase = mBusy && mOff == 3;
    fin     = mBusy && mOff == 4;
    first   = mBusy && mOff == 1;
    isWr    = (mType == 2'b01);
    isRd    = (mType == 2'b10);
    dk      = dackOn ? 4'(1 << mCh) : 4'b0;
    v = {mBusy, dk, dackOn, first,
         !(rdPhase && isRd), !(wrPhase && isWr), !(rdPhase && isWr), !(wrPhase && isRd),
         !(fin && mTc), 2'(mCh), mPc, first, fin, fin, fin && mIeop};
    return {13'b0, v};
  endfunction

  function automatic logic [31:0] dutVec();
    logic [18:0] v;
    v = {HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_OUT_N, IOW_OUT_N, EOP_N_OUT,
         activeChannel, programCondition, loadAddr, updateCurrentAddressReg,
         updateCurrentWordCountReg, intEOP};
    return {13'b0, v};
  endfunction

  localparam logic [31:0] RESET_VEC = {13'b0, 1'b0, 4'b0, 1'b0, 1'b0, 4'b1111, 1'b1,
                                       2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // Observation bookkeeping for directed scenarios.
  logic [3:0] grants[$];
  logic [3:0] prevDack = 4'b0;
  int updCnt, iorLow, memwLow, memrLow, iowLow, eopOutLow, intEopCnt;

  task automatic clearObs();
    grants.delete();
    updCnt = 0; iorLow = 0; memwLow = 0; memrLow = 0; iowLow = 0;
    eopOutLow = 0; intEopCnt = 0;
  endtask

  // One clock: model steps on the edge, outputs compared half a cycle later.
  task automatic cycle();
    @(posedge CLK);
    if (RESET_N) modelStep();
    @(negedge CLK);
    check("outputs", dutVec(), expVec());
    if (DACK != 4'b0 && prevDack == 4'b0) grants.push_back(DACK);
    prevDack = DACK;
    if (updateCurrentAddressReg) updCnt++;
    if (!IOR_OUT_N) iorLow++;
    if (!MEMW_N) memwLow++;
    if (!MEMR_N) memrLow++;
    if (!IOW_OUT_N) iowLow++;
    if (!EOP_N_OUT) eopOutLow++;
    if (intEOP) intEopCnt++;
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = 4'b0; HLDA = 1'b0; EOP_N_IN = 1'b1;
    cmdDisable = 1'b0; cmdRotatingPriority = 1'b0; channelMask = 4'b0;
    xferType = 8'b0; wordCountZero = 4'b0;
    modelReset();
    clearObs();
    repeat (3) cycle();
    check("reset_state", dutVec(), RESET_VEC);

    // Fixed priority with channels 0 and 2 requesting out of reset.
    DREQ = 4'b0101; HLDA = 1'b1;
    RESET_N = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (mBusy && mOff >= 1 && mCh == 0) DREQ[0] = 1'b0;
    end
    check("fixed_grant_count", 32'(grants.size() >= 2), 32'd1);
    if (grants.size() >= 2) begin
      check("fixed_first", 32'(grants[0]), 32'h1);
      check("fixed_second", 32'(grants[1]), 32'h4);
    end
    DREQ = 4'b0;
    repeat (8) cycle();

    // Rotating priority, all channels requesting.
    clearObs();
    cmdRotatingPriority = 1'b1; DREQ = 4'b1111;
    for (int i = 0; i < 60 && grants.size() < 5; i++) cycle();
    check("rot_grant_count", 32'(grants.size()), 32'd5);
    repeat (4) cycle();
    if (grants.size() >= 5) begin
      check("rot_g0", 32'(grants[0]), 32'h1);
      check("rot_g1", 32'(grants[1]), 32'h2);
      check("rot_g2", 32'(grants[2]), 32'h4);
      check("rot_g3", 32'(grants[3]), 32'h8);
      check("rot_g4", 32'(grants[4]), 32'h1);
    end
    check("rot_updates", 32'(updCnt), 32'd5);
    DREQ = 4'b0; cmdRotatingPriority = 1'b0;
    repeat (8) cycle();

    // Write transfer on channel 1 at terminal count.
    clearObs();
    xferType = 8'b00_00_01_00; wordCountZero = 4'b0010; DREQ = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (mBusy && mOff >= 1) DREQ = 4'b0;
    end
    check("wr_ior_cycles", 32'(iorLow), 32'd2);
    check("wr_memw_cycles", 32'(memwLow), 32'd1);
    check("wr_memr_cycles", 32'(memrLow), 32'd0);
    check("wr_iow_cycles", 32'(iowLow), 32'd0);
    check("wr_eop_out", 32'(eopOutLow), 32'd1);
    check("wr_int_eop", 32'(intEopCnt), 32'd1);
    check("wr_updates", 32'(updCnt), 32'd1);
    wordCountZero = 4'b0;

    // Masked request never raises HRQ.
    HLDA = 1'b0; xferType = 8'b00_00_00_10;
    channelMask = 4'b0001; DREQ = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("mask_hrq", 32'(HRQ), 32'd0);
      check("mask_pc", 32'(programCondition), 32'd1);
    end
    channelMask = 4'b0;
    cycle();
    check("unmask_hrq", 32'(HRQ), 32'd1);

    // HLDA withdrawn in S2 aborts the transfer.
    HLDA = 1'b1;
    begin
      bit reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
        cycle();
        reached = mBusy && mOff == 2;
      end
      check("abort_reach_s2", 32'(reached), 32'd1);
    end
    check("abort_s2_memr", 32'(MEMR_N), 32'd0);
    HLDA = 1'b0; DREQ = 4'b0;
    clearObs();
    cycle();
    check("abort_hrq", 32'(HRQ), 32'd0);
    check("abort_dack", 32'(DACK), 32'd0);
    check("abort_strobes", 32'({MEMR_N, MEMW_N, IOR_OUT_N, IOW_OUT_N, AEN}), 32'b11110);
    repeat (5) cycle();
    check("abort_no_update", 32'(updCnt), 32'd0);
    check("abort_no_inteop", 32'(intEopCnt), 32'd0);

    // Asynchronous reset in S3.
    HLDA = 1'b1; DREQ = 4'b0001; xferType = 8'b00_00_00_01;
    begin
      bit reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
        cycle();
        reached = mBusy && mOff == 3;
      end
      check("rst_reach_s3", 32'(reached), 32'd1);
    end
    RESET_N = 1'b0;
    #1;
    check("async_reset", dutVec(), RESET_VEC);
    modelReset();
    DREQ = 4'b0;
    @(negedge CLK);
    repeat (2) cycle();
    RESET_N = 1'b1;

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
      HLDA        = ($urandom_range(0, 9) != 0);
      cmdDisable  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) cmdRotatingPriority = ~cmdRotatingPriority;
      if ($urandom_range(0, 19) == 0) channelMask = 4'($urandom) & 4'($urandom);
      EOP_N_IN      = ($urandom_range(0, 5) != 0);
      wordCountZero = 4'($urandom);
      if (!mBusy && $urandom_range(0, 3) == 0) xferType = 8'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
